pic_ctl: RTL and testbench
==========================

// Module: pic_ctl
// PURPOSE
//  Parametrised programmable interrupt controller, successor of the fixed 2-line IRQ logic in the port block.
//  Sits on the CPU port bus (port_clk/port/port_o/port_w/port_i) and latches edge requests on NUM_IRQ lines.
//  Resolves fixed or rotating priority against an in-service register and presents a vector to the CPU.
//  The CPU interrupt handshake uses toggles (intr / intr_latch).
// PARAMETERS
//  NUM_IRQ    16      request lines, 2..16
//  BASE_PORT  16'h20  I/O base; registers at BASE+0..BASE+3
//  VECT_RST   8'h08   vector base after reset
// PORTS
//  clock       in   1   CPU host clock, all logic on posedge
//  reset       in   1   asynchronous, active-high
//  port_clk    in   1   1-cycle strobe: port access this cycle
//  port        in   16  I/O address
//  port_o      in   8   data from CPU
//  port_w      in   1   1=write, 0=read
//  port_i      out  8   read data, registered, valid the cycle after port_clk
//  irq_in      in   NUM_IRQ  request lines, sync to clock, rising edge = request
//  intr        out  1   toggles to request an interrupt
//  irq         out  8   vector = vect_base + level, stable while intr != intr_latch
//  intr_latch  in   1   CPU acknowledge: set equal to intr when the vector is taken
// BEHAVIOUR
//  Reset: port_i=0, intr=0, irq=0, IRR=0, ISR=0, IMR=0 (all enabled), vect_base=VECT_RST,
//    prio_base=0, rd_sel=IRR/low, aeoi=0, irq_in edge history = current irq_in.
//  Edge detect: irq_in registered once; rise sets IRR[i] on the next cycle.
//    IRR latches even when masked; the mask gates dispatch only.
//    Set and clear of the same IRR bit in one cycle -> set wins.
//  Priority: rank(i) = (i - prio_base) mod NUM_IRQ; rank 0 is highest.
//  Dispatch when all hold:
//    - intr == intr_latch (previous interrupt acknowledged);
//    - a candidate exists: the highest-ranked i with IRR[i] & ~IMR[i];
//    - its rank is strictly above every set ISR bit.
//  On dispatch, in one cycle:
//    - irq <= vect_base + i;
//    - IRR[i] <= 0;
//    - ISR[i] <= ~aeoi; in AEOI mode, with the rotate bit, prio_base <= i+1;
//    - intr <= ~intr_latch.
//  No further dispatch until intr_latch == intr. Dispatch latency from an edge on irq_in is 3 clocks.
//  Dispatch decision uses the ISR value from the previous cycle. An EOI written in the same cycle takes effect next cycle.
//  BASE+0 write, port_o[7:5]:
//    001 non-specific EOI: clear highest-ranked ISR bit
//    011 specific EOI: clear ISR[port_o[3:0]]
//    101 rotate on non-specific EOI: clear it, then prio_base <= level+1
//    111 set priority: prio_base <= port_o[3:0]+1
//    000 with port_o[3]=1: rd_sel <= port_o[1:0] (b0: 0=IRR,1=ISR; b1: 0=low byte,1=high byte)
//    other codes: ignored
//    EOI with no ISR bit set, or a level >= NUM_IRQ: no effect.
//  BASE+1 r/w: IMR[7:0].
//  BASE+2 r/w: IMR[15:8]; reads 0 and writes are ignored when NUM_IRQ <= 8.
//  BASE+3 write: vect_base <= {port_o[7:3],3'b0}; port_o[0] -> aeoi.
//  BASE+3 read: {vect_base[7:3], 2'b0, aeoi}.
//  BASE+0 read: byte selected by rd_sel. Bits at or above NUM_IRQ read 0.
//  Reads of other addresses leave port_i unchanged. Reads have no side effects.
//  Vector arithmetic is 8-bit and wraps (base F8 + level 10 -> 02).
//  Reset mid-handshake: intr returns to 0 asynchronously. Requests pending at reset are lost.
// STRUCTURE
//  pic_pkg: register offsets, OCW2 codes (EOI_NS, EOI_SP, EOI_ROT, SET_PRIO), rd_sel encoding.
//  Sub-module pic_prio_enc: combinational, inputs {req, prio_base}, outputs {valid, level, rank}.
//    Instantiated twice: once on IRR&~IMR, once on ISR.
//  Top level holds the registers, edge detect, port decode and the intr toggle.
// TESTING
//  1. irq_in[0] rises, IMR=0, base 08 -> 3 clocks later intr toggles, irq=08, ISR[0]=1, IRR=0.
//  2. irq_in[3] and irq_in[1] rise together -> irq=09 first.
//     Ack, then write 20h<=20h (EOI) -> irq=0B after ack plus 1 clk.
//  3. IMR low=04h, pulse irq_in[2] -> no intr. Write IMR=00h -> dispatch irq=0A. IRR read shows bit2 until dispatch.
//  4. Nested: ISR[5] set, irq_in[2] rises -> dispatch 0A. irq_in[7] rises -> held until EOIs clear ISR[5].
//  5. Write 20h<=E3h (prio_base=4), raise irq_in[0] and irq_in[5] -> irq=0D first.
//     AEOI with rotate -> ISR stays 0.
//  6. Assert reset while intr != intr_latch -> intr=0, ISR=IRR=0, vect_base reads back 08.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller.
// Covers register offsets, command codes, read-select bits and level wrap arithmetic.
package pic_pkg;

  localparam int MAX_IRQ = 16;

  localparam logic [1:0] REG_OCW    = 2'd0;
  localparam logic [1:0] REG_IMR_LO = 2'd1;
  localparam logic [1:0] REG_IMR_HI = 2'd2;
  localparam logic [1:0] REG_VEC    = 2'd3;

  typedef enum logic [2:0] {
    OCW_RDSEL = 3'b000,
    EOI_NS    = 3'b001,
    EOI_SP    = 3'b011,
    EOI_ROT   = 3'b101,
    SET_PRIO  = 3'b111
  } ocw_code_e;

  localparam int RD_ISR_BIT  = 0;
  localparam int RD_HIGH_BIT = 1;

  function automatic logic [3:0] wrap_lvl(input logic [4:0] v, input int n);
    return 4'(int'(v) % n);
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating-priority encoder: picks the set request with the lowest rank (i - prio_base) mod N.
// Purely combinational, zero latency; no flow control.
module pic_prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   prio_base,
  output logic         valid,
  output logic [3:0]   level,
  output logic [3:0]   rank
);

  int         idx;
  logic [3:0] idx4;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid = 1'b0;
    level = 4'd0;
    rank  = 4'd0;
    idx   = 0;
    idx4  = 4'd0;
    for (int r = N - 1; r >= 0; r--) begin
      idx = int'(prio_base) + r;
      if (idx >= N) idx = idx - N;
      idx4 = 4'(idx);
      if (req[idx4]) begin
        valid = 1'b1;
        level = idx4;
        rank  = 4'(r);
      end
    end
  end

endmodule

// File: rtl/pic_ctl.sv
// Interrupt controller on the CPU port bus: edge-latched requests, fixed/rotating priority, vectored toggle handshake.
// irq_in edge to intr toggle takes 3 clocks; dispatch stalls while intr != intr_latch.
module pic_ctl
  import pic_pkg::*;
#(
  parameter int          NUM_IRQ   = 16,
  parameter logic [15:0] BASE_PORT = 16'h20,
  parameter logic [7:0]  VECT_RST  = 8'h08
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               port_clk,
  input  logic [15:0]        port,
  input  logic [7:0]         port_o,
  input  logic               port_w,
  output logic [7:0]         port_i,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               intr,
  output logic [7:0]         irq,
  input  logic               intr_latch
);

  logic [NUM_IRQ-1:0] irq_s, irq_d, irr, isr, imr, pend, rise;
  logic [NUM_IRQ-1:0] irr_n, isr_n, imr_n;
  logic               primed, aeoi, aeoi_rot, aeoi_n, rot_n;
  logic [3:0]         prio_base, prio_n;
  logic [7:0]         vect_base, vect_n, rd_dat;
  logic [1:0]         rd_sel, rdsel_n, reg_sel;
  logic [15:0]        off, imr_wr, irr16, isr16, imr16, sel16;
  logic               hit_wr, hit_rd, dispatch;
  logic               c_vld, s_vld;
  logic [3:0]         c_lvl, c_rank, s_lvl, s_rank;

  assign off     = port - BASE_PORT;
  assign reg_sel = off[1:0];
  assign hit_wr  = port_clk && port_w && (off[15:2] == 14'd0);
  assign hit_rd  = port_clk && !port_w && (off[15:2] == 14'd0);

  assign pend = irr & ~imr;
  assign rise = primed ? (irq_s & ~irq_d) : {NUM_IRQ{1'b0}};

  pic_prio_enc #(.N(NUM_IRQ)) u_cand (
    .req(pend), .prio_base(prio_base), .valid(c_vld), .level(c_lvl), .rank(c_rank)
  );

  pic_prio_enc #(.N(NUM_IRQ)) u_isr (
    .req(isr), .prio_base(prio_base), .valid(s_vld), .level(s_lvl), .rank(s_rank)
  );

  assign dispatch = (intr == intr_latch) && c_vld && (!s_vld || (c_rank < s_rank));

  always_comb begin
    irr_n   = irr;
    isr_n   = isr;
    imr_n   = imr;
    prio_n  = prio_base;
    vect_n  = vect_base;
    aeoi_n  = aeoi;
    rot_n   = aeoi_rot;
    rdsel_n = rd_sel;
    imr_wr  = 16'(imr);
    if (dispatch) begin
      irr_n[c_lvl] = 1'b0;
      if (aeoi && aeoi_rot) prio_n = wrap_lvl({1'b0, c_lvl} + 5'd1, NUM_IRQ);
    end
    irr_n = irr_n | rise;
    // A port write to the priority base overrides an AEOI rotation in the same cycle.
    if (hit_wr) begin
      case (reg_sel)
        REG_OCW: begin
          case (port_o[7:5])
            EOI_NS:   if (s_vld) isr_n[s_lvl] = 1'b0;
            EOI_SP:   if ({1'b0, port_o[3:0]} < 5'(NUM_IRQ)) isr_n[port_o[3:0]] = 1'b0;
            EOI_ROT:  if (s_vld) begin
                        isr_n[s_lvl] = 1'b0;
                        prio_n = wrap_lvl({1'b0, s_lvl} + 5'd1, NUM_IRQ);
                      end
            SET_PRIO: prio_n = wrap_lvl({1'b0, port_o[3:0]} + 5'd1, NUM_IRQ);
            OCW_RDSEL: if (port_o[3]) rdsel_n = port_o[1:0];
            default: ;
          endcase
        end
        REG_IMR_LO: begin
          imr_wr[7:0] = port_o;
          imr_n = imr_wr[NUM_IRQ-1:0];
        end
        REG_IMR_HI: begin
          if (NUM_IRQ > 8) begin
            imr_wr[15:8] = port_o;
            imr_n = imr_wr[NUM_IRQ-1:0];
          end
        end
        default: begin
          vect_n = {port_o[7:3], 3'b000};
          aeoi_n = port_o[0];
          rot_n  = port_o[1];
        end
      endcase
    end
    if (dispatch && !aeoi) isr_n[c_lvl] = 1'b1;
  end

  always_comb begin
    irr16 = 16'(irr);
    isr16 = 16'(isr);
    imr16 = 16'(imr);
    sel16 = rd_sel[RD_ISR_BIT] ? isr16 : irr16;
    case (reg_sel)
      REG_OCW:    rd_dat = rd_sel[RD_HIGH_BIT] ? sel16[15:8] : sel16[7:0];
      REG_IMR_LO: rd_dat = imr16[7:0];
      REG_IMR_HI: rd_dat = imr16[15:8];
      default:    rd_dat = {vect_base[7:3], 2'b00, aeoi};
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_s     <= '0;
      irq_d     <= '0;
      primed    <= 1'b0;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      prio_base <= 4'd0;
      vect_base <= VECT_RST;
      aeoi      <= 1'b0;
      aeoi_rot  <= 1'b0;
      rd_sel    <= 2'b00;
      port_i    <= 8'h00;
      intr      <= 1'b0;
      irq       <= 8'h00;
    end else begin
      irq_s <= irq_in;
      // First cycle out of reset seeds the edge history with the live line levels.
      irq_d     <= primed ? irq_s : irq_in;
      primed    <= 1'b1;
      irr       <= irr_n;
      isr       <= isr_n;
      imr       <= imr_n;
      prio_base <= prio_n;
      vect_base <= vect_n;
      aeoi      <= aeoi_n;
      aeoi_rot  <= rot_n;
      rd_sel    <= rdsel_n;
      if (hit_rd) port_i <= rd_dat;
      if (dispatch) begin
        irq  <= vect_base + {4'b0000, c_lvl};
        intr <= ~intr_latch;
      end
    end
  end

endmodule

// File: tb/tb_pic_ctl.sv
// Randomized bench for pic_ctl against a transaction-level model of IRR/ISR/IMR and priority rules.
module tb_pic_ctl;
  localparam int N = 16;

  logic         clock = 1'b0;
  logic         reset, port_clk, port_w, intr, intr_latch;
  logic [15:0]  port;
  logic [7:0]   port_o, port_i, irq;
  logic [N-1:0] irq_in;

  int n_checks = 0;
  int n_errors = 0;

  bit [15:0] m_irr, m_isr, m_imr;
  int        m_base;
  bit [7:0]  m_vect;
  bit        m_aeoi, m_rot;
  logic [7:0] first_vec;
  int        n_disp;

  pic_ctl #(.NUM_IRQ(N), .BASE_PORT(16'h20), .VECT_RST(8'h08)) dut (
    .clock(clock), .reset(reset), .port_clk(port_clk), .port(port), .port_o(port_o),
    .port_w(port_w), .port_i(port_i), .irq_in(irq_in), .intr(intr), .irq(irq),
    .intr_latch(intr_latch)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic port_wr(input logic [15:0] a, input logic [7:0] d);
    port_clk = 1'b1; port = a; port_o = d; port_w = 1'b1;
    tick(1);
    port_clk = 1'b0; port_w = 1'b0;
  endtask

  task automatic port_rd(input logic [15:0] a, output logic [7:0] d);
    port_clk = 1'b1; port = a; port_w = 1'b0;
    tick(1);
    port_clk = 1'b0;
    d = port_i;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_in = mask;
    tick(1);
    irq_in = '0;
    m_irr |= mask;
  endtask

  function automatic int best(input bit [15:0] req, input int base);
    int idx;
    for (int r = 0; r < N; r++) begin
      idx = (base + r) % N;
      if (req[idx[3:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic int rank_of(input int lvl, input int base);
    return (lvl - base + N) % N;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_imr = '0; m_base = 0;
    m_vect = 8'h08; m_aeoi = 1'b0; m_rot = 1'b0;
  endtask

  task automatic eoi_ns();
    int s;
    port_wr(16'h20, 8'h20);
    s = best(m_isr, m_base);
    if (s >= 0) m_isr[s] = 1'b0;
  endtask

  task automatic eoi_rot();
    int s;
    port_wr(16'h20, 8'hA0);
    s = best(m_isr, m_base);
    if (s >= 0) begin
      m_isr[s] = 1'b0;
      m_base = (s + 1) % N;
    end
  endtask

  task automatic eoi_sp(input int l);
    port_wr(16'h20, 8'h60 | 8'(l));
    m_isr[l] = 1'b0;
  endtask

  task automatic set_prio(input int v);
    port_wr(16'h20, 8'hE0 | 8'(v));
    m_base = (v + 1) % N;
  endtask

  task automatic wr_vec(input logic [7:0] d);
    port_wr(16'h23, d);
    m_vect = d & 8'hF8; m_aeoi = d[0]; m_rot = d[1];
  endtask

  task automatic rd_sel_read(input int sel, output logic [7:0] d);
    port_wr(16'h20, 8'h08 | 8'(sel));
    port_rd(16'h20, d);
  endtask

  // Let the DUT run, then service every dispatch the model says must happen, in order.
  task automatic settle();
    int c, s;
    bit go;
    n_disp = 0;
    first_vec = 8'hxx;
    tick(4);
    for (int k = 0; k < N + 2; k++) begin
      c = best(m_irr & ~m_imr, m_base);
      s = best(m_isr, m_base);
      go = (c >= 0) && (s < 0 || rank_of(c, m_base) < rank_of(s, m_base));
      if (!go) begin
        chk("idle", 32'(intr ^ intr_latch), 0);
        break;
      end
      chk("pending", 32'(intr ^ intr_latch), 1);
      chk("vector", 32'(irq), (32'(m_vect) + 32'(c)) & 32'hFF);
      if (n_disp == 0) first_vec = irq;
      n_disp++;
      m_irr[c] = 1'b0;
      if (!m_aeoi) m_isr[c] = 1'b1;
      else if (m_rot) m_base = (c + 1) % N;
      intr_latch = intr;
      tick(3);
    end
  endtask

  task automatic check_regs();
    logic [7:0] d;
    bit [15:0] src;
    for (int s = 0; s < 4; s++) begin
      rd_sel_read(s, d);
      src = s[0] ? m_isr : m_irr;
      chk(s[0] ? "rd_isr" : "rd_irr", 32'(d), 32'(s[1] ? src[15:8] : src[7:0]));
    end
    port_rd(16'h21, d); chk("rd_imr_lo", 32'(d), 32'(m_imr[7:0]));
    port_rd(16'h22, d); chk("rd_imr_hi", 32'(d), 32'(m_imr[15:8]));
    port_rd(16'h23, d); chk("rd_vec", 32'(d), 32'({m_vect[7:3], 2'b00, m_aeoi}));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] v;
    logic [N-1:0] mask;
    int op;
    reset = 1'b1; port_clk = 1'b0; port = '0; port_o = '0; port_w = 1'b0;
    irq_in = '0; intr_latch = 1'b0;
    model_reset();
    #23 reset = 1'b0;
    tick(2);

    chk("rst_intr", 32'(intr), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_port_i", 32'(port_i), 0);
    port_rd(16'h20, d); chk("rst_irr", 32'(d), 0);
    port_rd(16'h21, d); chk("rst_imr", 32'(d), 0);
    port_rd(16'h23, d); chk("rst_vec", 32'(d), 32'h08);

    // Single request: exact 3-clock latency and state after dispatch.
    irq_in[0] = 1'b1;
    tick(2); chk("t1_lat2", 32'(intr), 0);
    tick(1); chk("t1_lat3", 32'(intr), 1); chk("t1_vec", 32'(irq), 32'h08);
    irq_in = '0;
    rd_sel_read(1, d); chk("t1_isr", 32'(d), 32'h01);
    rd_sel_read(0, d); chk("t1_irr", 32'(d), 0);

    // Reset while the handshake is outstanding.
    #2 reset = 1'b1;
    #1 chk("t6_intr_async", 32'(intr), 0);
    intr_latch = 1'b0;
    model_reset();
    tick(1);
    reset = 1'b0;
    tick(2);
    port_rd(16'h20, d); chk("t6_irr", 32'(d), 0);
    port_rd(16'h23, d); chk("t6_vec", 32'(d), 32'h08);
    rd_sel_read(1, d); chk("t6_isr", 32'(d), 0);

    // Simultaneous requests, second held until EOI.
    pulse(16'h000A);
    settle(); chk("t2_first", 32'(first_vec), 32'h09); chk("t2_count", 32'(n_disp), 1);
    eoi_ns();
    settle(); chk("t2_second", 32'(first_vec), 32'h0B);
    eoi_ns();

    // Masked request latches in IRR but does not dispatch.
    port_wr(16'h21, 8'h04); m_imr[7:0] = 8'h04;
    pulse(16'h0004);
    settle(); chk("t3_masked", 32'(n_disp), 0);
    rd_sel_read(0, d); chk("t3_irr", 32'(d), 32'h04);
    port_wr(16'h21, 8'h00); m_imr[7:0] = 8'h00;
    settle(); chk("t3_unmask", 32'(first_vec), 32'h0A);
    eoi_ns();

    // Rotated priority, then AEOI with rotation.
    set_prio(3);
    pulse(16'h0021);
    settle(); chk("t5_first", 32'(first_vec), 32'h0D); chk("t5_count", 32'(n_disp), 1);
    wr_vec(8'h0B);
    eoi_ns();
    settle(); chk("t5_aeoi_vec", 32'(first_vec), 32'h08);
    rd_sel_read(1, d); chk("t5_isr_zero", 32'(d), 0);

    // 8-bit vector wrap.
    wr_vec(8'hF8);
    pulse(16'h0400);
    settle(); chk("wrap_vec", 32'(first_vec), 32'h02);
    eoi_ns();
    check_regs();
    port_rd(16'h24, d); chk("rd_other_addr", 32'(d), 32'({m_vect[7:3], 2'b00, m_aeoi}));

    for (int step = 0; step < 300; step++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          mask = N'($urandom) & N'($urandom);
          pulse(mask);
        end
        3: eoi_ns();
        4: eoi_sp($urandom_range(0, N - 1));
        5: eoi_rot();
        6: set_prio($urandom_range(0, 15));
        7: begin
          v = 8'($urandom) & 8'($urandom) & 8'($urandom);
          if ($urandom_range(0, 1) == 0) begin
            port_wr(16'h21, v); m_imr[7:0] = v;
          end else begin
            port_wr(16'h22, v); m_imr[15:8] = v;
          end
        end
        8: check_regs();
        default: begin
          v = 8'($urandom);
          if ($urandom_range(0, 3) != 0) v[0] = 1'b0;
          wr_vec(v);
        end
      endcase
      settle();
    end
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
